// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says colour datapath.
package simon_pkg;

    localparam int unsigned TIMER_W      = 25;
    localparam int unsigned FAIL_FLASHES = 3;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    typedef enum logic [2:0] {
        IDLE,
        PLAY_ON,
        PLAY_OFF,
        CHECK,
        FAIL
    } pb_state_t;

    // LED drive for a colour: bit position equals the colour code.
    function automatic logic [3:0] onehot(input colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/seq_mem.sv
// Colour sequence storage: synchronous write, asynchronous read, no reset.
module seq_mem
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    localparam int unsigned AW     = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  colour_t       wdata,
    input  logic [AW-1:0] raddr,
    output colour_t       rdata
);

    colour_t mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/colour_playback_ctrl.sv
// Stores, replays and checks the Simon Says colour sequence.
// Build option: define FAIL_FLASH_EN to flash the expected colour after a wrong guess.
module colour_playback_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned BASE_CYCLES = 20_000_000,
    parameter int unsigned STEP_CYCLES = 2_000_000,
    parameter int unsigned MIN_CYCLES  = 4_000_000,
    localparam int unsigned LEN_W      = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             append,
    input  colour_t          colour_in,
    input  logic             play,
    input  logic [2:0]       speed,
    input  logic             guess_valid,
    input  colour_t          guess,
    output logic [3:0]       led,
    output logic             busy,
    output logic             play_done,
    output logic             result_valid,
    output logic             result_ok,
    output logic             round_done,
    output logic [LEN_W-1:0] length
);

    localparam int unsigned AW = $clog2(MAX_LEN);

    pb_state_t          state, state_d;
    logic [AW-1:0]      idx, idx_d;
    logic [TIMER_W-1:0] timer, timer_d;
    logic [TIMER_W-1:0] on_cyc, on_cyc_d, on_cyc_c;
    logic [LEN_W-1:0]   length_d;
    colour_t            cur_colour;
    colour_t            rdata;
    logic               we;
    logic [3:0]         led_d;
    logic               busy_d, play_done_d, result_valid_d, result_ok_d, round_done_d;
    logic [31:0]        step_prod_c;
    logic               last_idx_c;

`ifdef FAIL_FLASH_EN
    localparam int unsigned FLASH_W = $clog2(FAIL_FLASHES);
    logic               fail_lit, fail_lit_d;
    logic [FLASH_W-1:0] flash_cnt, flash_cnt_d;
`endif

    seq_mem #(
        .MAX_LEN (MAX_LEN)
    ) u_seq_mem (
        .clk   (clk),
        .we    (we),
        .waddr (AW'(length)),
        .wdata (colour_in),
        .raddr (idx_d),
        .rdata (rdata)
    );

    // Per-speed on/off time, clamped at the floor.
    assign step_prod_c = 32'(speed) * 32'(STEP_CYCLES);
    assign on_cyc_c    = (step_prod_c + 32'(MIN_CYCLES) >= 32'(BASE_CYCLES))
                       ? TIMER_W'(MIN_CYCLES)
                       : TIMER_W'(32'(BASE_CYCLES) - step_prod_c);
    assign last_idx_c  = (LEN_W'(idx) == length - LEN_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d        = state;
        idx_d          = idx;
        timer_d        = timer;
        on_cyc_d       = on_cyc;
        length_d       = length;
        we             = 1'b0;
        play_done_d    = 1'b0;
        result_valid_d = 1'b0;
        result_ok_d    = 1'b0;
        round_done_d   = 1'b0;
`ifdef FAIL_FLASH_EN
        fail_lit_d     = fail_lit;
        flash_cnt_d    = flash_cnt;
`endif
        if (clear) begin
            state_d  = IDLE;
            idx_d    = '0;
            timer_d  = '0;
            length_d = '0;
`ifdef FAIL_FLASH_EN
            fail_lit_d  = 1'b0;
            flash_cnt_d = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (append) begin
                        if (length < LEN_W'(MAX_LEN)) begin
                            we       = 1'b1;
                            length_d = length + LEN_W'(1);
                        end
                    end else if (play) begin
                        if (length == '0) begin
                            play_done_d = 1'b1;
                        end else begin
                            on_cyc_d = on_cyc_c;
                            idx_d    = '0;
                            timer_d  = on_cyc_c - TIMER_W'(1);
                            state_d  = PLAY_ON;
                        end
                    end
                end
                PLAY_ON: begin
                    if (timer == '0) begin
                        timer_d = on_cyc - TIMER_W'(1);
                        state_d = PLAY_OFF;
                    end else begin
                        timer_d = timer - TIMER_W'(1);
                    end
                end
                PLAY_OFF: begin
                    if (timer == '0) begin
                        if (last_idx_c) begin
                            play_done_d = 1'b1;
                            idx_d       = '0;
                            state_d     = CHECK;
                        end else begin
                            idx_d   = idx + AW'(1);
                            timer_d = on_cyc - TIMER_W'(1);
                            state_d = PLAY_ON;
                        end
                    end else begin
                        timer_d = timer - TIMER_W'(1);
                    end
                end
                CHECK: begin
                    if (guess_valid) begin
                        result_valid_d = 1'b1;
                        if (guess == cur_colour) begin
                            result_ok_d = 1'b1;
                            if (last_idx_c) begin
                                round_done_d = 1'b1;
                                idx_d        = '0;
                                state_d      = IDLE;
                            end else begin
                                idx_d = idx + AW'(1);
                            end
                        end else begin
`ifdef FAIL_FLASH_EN
                            // idx is held so the flash shows the colour that was expected.
                            timer_d     = on_cyc - TIMER_W'(1);
                            fail_lit_d  = 1'b1;
                            flash_cnt_d = '0;
                            state_d     = FAIL;
`else
                            idx_d   = '0;
                            state_d = IDLE;
`endif
                        end
                    end
                end
`ifdef FAIL_FLASH_EN
                FAIL: begin
                    if (timer == '0) begin
                        timer_d = on_cyc - TIMER_W'(1);
                        if (fail_lit) begin
                            fail_lit_d = 1'b0;
                        end else if (flash_cnt == FLASH_W'(FAIL_FLASHES - 1)) begin
                            idx_d   = '0;
                            timer_d = '0;
                            state_d = IDLE;
                        end else begin
                            flash_cnt_d = flash_cnt + FLASH_W'(1);
                            fail_lit_d  = 1'b1;
                        end
                    end else begin
                        timer_d = timer - TIMER_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // LED and busy are registered from the next state so they line up with it.
        led_d = 4'b0000;
        case (state_d)
            PLAY_ON: led_d = onehot(rdata);
`ifdef FAIL_FLASH_EN
            FAIL:    led_d = fail_lit_d ? onehot(rdata) : 4'b0000;
`endif
            default: led_d = 4'b0000;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= '0;
            timer        <= '0;
            on_cyc       <= '0;
            length       <= '0;
            cur_colour   <= RED;
            led          <= 4'b0000;
            busy         <= 1'b0;
            play_done    <= 1'b0;
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
            round_done   <= 1'b0;
        end else begin
            idx          <= idx_d;
            timer        <= timer_d;
            on_cyc       <= on_cyc_d;
            length       <= length_d;
            cur_colour   <= rdata;
            led          <= led_d;
            busy         <= busy_d;
            play_done    <= play_done_d;
            result_valid <= result_valid_d;
            result_ok    <= result_ok_d;
            round_done   <= round_done_d;
        end
    end

`ifdef FAIL_FLASH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_lit  <= 1'b0;
            flash_cnt <= '0;
        end else begin
            fail_lit  <= fail_lit_d;
            flash_cnt <= flash_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_colour_playback_ctrl.sv
// Self-checking bench for colour_playback_ctrl against a sequence-level reference model.
module tb_colour_playback_ctrl;
    import simon_pkg::*;

    localparam int BASE = 10;
    localparam int STEP = 2;
    localparam int MINC = 4;
    localparam int CAP  = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear, append, play, guess_valid;
    colour_t    colour_in, guess;
    logic [2:0] speed;
    logic [3:0] led;
    logic       busy, play_done, result_valid, result_ok, round_done;
    logic [5:0] length;

    int checks = 0;
    int errors = 0;
    int q[$];
    int cur_oc = BASE;

    always #5 clk = ~clk;

    colour_playback_ctrl #(
        .MAX_LEN     (CAP),
        .BASE_CYCLES (BASE),
        .STEP_CYCLES (STEP),
        .MIN_CYCLES  (MINC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .append       (append),
        .colour_in    (colour_in),
        .play         (play),
        .speed        (speed),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .led          (led),
        .busy         (busy),
        .play_done    (play_done),
        .result_valid (result_valid),
        .result_ok    (result_ok),
        .round_done   (round_done),
        .length       (length)
    );

    function automatic int on_cycles(input int s);
        int v;
        v = BASE - s * STEP;
        return (v < MINC) ? MINC : v;
    endfunction

    function automatic logic [3:0] lamp(input int c);
        logic [3:0] r;
        r    = 4'b0000;
        r[c] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_append(input int c);
        colour_in = colour_t'(2'(c));
        append    = 1'b1;
        step();
        append    = 1'b0;
        if (q.size() < CAP) q.push_back(c);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        q.delete();
        chk("clear_length", 32'(length), 0);
        chk("clear_busy", 32'(busy), 0);
    endtask

    // Play and follow the whole light show cycle by cycle.
    task automatic do_play(input int s);
        speed = 3'(s);
        play  = 1'b1;
        step();
        play  = 1'b0;
        if (q.size() == 0) begin
            chk("empty_play_done", 32'(play_done), 1);
            chk("empty_busy", 32'(busy), 0);
            chk("empty_led", 32'(led), 0);
            return;
        end
        cur_oc = on_cycles(s);
        chk("play_busy", 32'(busy), 1);
        chk("play_done_early", 32'(play_done), 0);
        foreach (q[i]) begin
            for (int k = 0; k < cur_oc; k++) begin
                chk("led_on", 32'(led), 32'(lamp(q[i])));
                speed = 3'($urandom);
                step();
            end
            for (int k = 0; k < cur_oc; k++) begin
                chk("led_off", 32'(led), 0);
                step();
            end
        end
        chk("play_done", 32'(play_done), 1);
        chk("check_led", 32'(led), 0);
        chk("check_busy", 32'(busy), 1);
    endtask

    task automatic fail_flash(input int c);
`ifdef FAIL_FLASH_EN
        chk("fail_busy", 32'(busy), 1);
        for (int f = 0; f < FAIL_FLASHES; f++) begin
            for (int k = 0; k < cur_oc; k++) begin
                chk("flash_on", 32'(led), 32'(lamp(c)));
                step();
            end
            for (int k = 0; k < cur_oc; k++) begin
                chk("flash_off", 32'(led), 0);
                step();
            end
        end
        chk("after_flash_busy", 32'(busy), 0);
        chk("after_flash_led", 32'(led), 0);
`else
        chk("miss_busy", 32'(busy), 0);
        chk("miss_led", 32'(led), 0);
        chk("miss_colour_in_range", 32'(c < 4), 1);
`endif
    endtask

    // miss_at < 0 guesses everything right; otherwise guesses q[miss_at]+off there.
    task automatic do_guesses(input int miss_at, input int off);
        for (int i = 0; i < q.size(); i++) begin
            int g;
            g           = (i == miss_at) ? (q[i] + off) % 4 : q[i];
            guess       = colour_t'(2'(g));
            guess_valid = 1'b1;
            step();
            guess_valid = 1'b0;
            chk("result_valid", 32'(result_valid), 1);
            chk("result_ok", 32'(result_ok), 32'(g == q[i]));
            chk("round_done", 32'(round_done), 32'((g == q[i]) && (i == q.size() - 1)));
            if (g != q[i]) begin
                fail_flash(q[i]);
                return;
            end
            if (i == q.size() - 1) begin
                step();
                chk("round_busy", 32'(busy), 0);
                chk("round_rv_low", 32'(result_valid), 0);
            end else if ($urandom_range(0, 1) == 1) begin
                step();
                chk("rv_gap", 32'(result_valid), 0);
            end
        end
    endtask

    initial begin
        int first;
        reset       = 1'b0;
        clear       = 1'b0;
        append      = 1'b0;
        play        = 1'b0;
        guess_valid = 1'b0;
        colour_in   = RED;
        guess       = RED;
        speed       = 3'd0;

        step();
        step();
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_length", 32'(length), 0);
        chk("rst_pulses", 32'({play_done, result_valid, result_ok, round_done}), 0);
        reset = 1'b1;
        step();

        // Directed: RED BLUE GREEN at speeds 0, 5, 2.
        do_append(0);
        do_append(2);
        do_append(1);
        chk("length3", 32'(length), 3);
        do_play(0);
        do_guesses(-1, 0);
        do_play(5);
        do_guesses(-1, 0);
        do_play(2);
        do_guesses(-1, 0);
        // RED then YELLOW: second guess wrong, BLUE expected.
        do_play(0);
        do_guesses(1, 1);
        chk("length_kept", 32'(length), 3);

        // Random sequences, speeds and guess outcomes.
        for (int r = 0; r < 6; r++) begin
            int n;
            do_clear();
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) do_append($urandom_range(0, 3));
            chk("rand_length", 32'(length), 32'(q.size()));
            do_play($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_guesses($urandom_range(0, n - 1), $urandom_range(1, 3));
            else
                do_guesses(-1, 0);
        end

        // Saturation: the 33rd colour differs from the first and must not appear.
        do_clear();
        for (int j = 0; j < CAP; j++) do_append($urandom_range(0, 3));
        first = q[0];
        do_append((first + 1) % 4);
        chk("sat_length", 32'(length), CAP);
        chk("sat_model", 32'(q.size()), CAP);
        do_play(7);
        do_guesses(-1, 0);

        // Empty play.
        do_clear();
        do_play(3);
        step();
        chk("empty_pulse_once", 32'(play_done), 0);

        // Append and play together: append wins.
        colour_in = GREEN;
        append    = 1'b1;
        play      = 1'b1;
        step();
        append    = 1'b0;
        play      = 1'b0;
        q.push_back(1);
        chk("ap_length", 32'(length), 1);
        chk("ap_busy", 32'(busy), 0);
        step();
        chk("ap_busy2", 32'(busy), 0);
        chk("ap_led", 32'(led), 0);
        chk("ap_play_done", 32'(play_done), 0);

        // Asynchronous reset in the middle of PLAY_ON.
        speed = 3'd0;
        play  = 1'b1;
        step();
        play  = 1'b0;
        step();
        step();
        chk("pre_rst_led", 32'(led), 32'(lamp(1)));
        #2 reset = 1'b0;
        #1;
        chk("async_led", 32'(led), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_length", 32'(length), 0);
        q.delete();
        step();
        reset = 1'b1;
        step();

        // Clear in the middle of CHECK.
        do_append(3);
        do_append(0);
        do_play(6);
        guess       = YELLOW;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        chk("pre_clear_ok", 32'(result_ok), 1);
        do_clear();
        chk("clear_rv", 32'(result_valid), 0);
        step();
        chk("clear_idle_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/colour_playback_ctrl.md
Name: colour_playback_ctrl

Overview:
Sequencer for the Simon Says colour datapath. It stores the growing colour sequence, replays it on the four LEDs with speed-dependent on/off timing, then checks the player's guesses one by one against the stored sequence. It sits between the game FSM (append, play and clear commands plus the speed level) and the LED/key front end, and it replaces the ad-hoc pulse/check_round handshake.

Parameters:
- MAX_LEN, 32, sequence capacity in colours (power of 2); length counter width is $clog2(MAX_LEN)+1.
- BASE_CYCLES, 20_000_000, on-time and off-time at speed 0.
- STEP_CYCLES, 2_000_000, cycles removed per speed level.
- MIN_CYCLES, 4_000_000, floor for on-time and off-time.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of sequence and state.
- append  in  1  one-cycle request to add colour_in at the end of the sequence.
- colour_in  in  2  colour to append (colour_t).
- play  in  1  one-cycle request to replay the sequence.
- speed  in  3  speed level; sampled when a play is accepted.
- guess_valid  in  1  one-cycle strobe: the player has pressed a key.
- guess  in  2  colour of the guess.
- led  out  4  one-hot LED drive; 0 when dark.
- busy  out  1  high in every state except IDLE.
- play_done  out  1  one-cycle pulse when playback finishes.
- result_valid  out  1  one-cycle pulse per accepted guess.
- result_ok  out  1  guess matched; valid only with result_valid.
- round_done  out  1  one-cycle pulse when all guesses matched.
- length  out  6  current number of stored colours.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; length, idx and timer are 0; led, busy, play_done, result_valid, result_ok and round_done are 0. Memory contents are don't-care.
- clear (synchronous): wins over every other input in every state. Next cycle: IDLE, length 0, idx 0, all pulse outputs 0.
- IDLE:
  - append: mem[length] <= colour_in; length increments and saturates at MAX_LEN (a write at full length is dropped).
  - play with length==0: play_done pulses next cycle, state stays IDLE.
  - play with length>0: latch on_cyc = max(BASE_CYCLES - speed*STEP_CYCLES, MIN_CYCLES); idx <= 0; timer <= on_cyc-1; go to PLAY_ON.
  - append and play in the same cycle: append wins, play is dropped.
  - guess_valid is ignored.
- PLAY_ON: led = onehot(mem[idx]). Timer counts down to 0, then reload on_cyc-1 and go to PLAY_OFF. Each colour is lit for exactly on_cyc cycles.
- PLAY_OFF: led = 0 for on_cyc cycles. On expiry:
  - idx==length-1: pulse play_done, idx <= 0, go to CHECK.
  - otherwise: idx++ and go to PLAY_ON.
- CHECK: led = 0. On guess_valid, compare guess with mem[idx]. result_valid pulses the next cycle with result_ok set accordingly.
  - Match and idx==length-1: round_done pulses in the same cycle as result_valid; go to IDLE.
  - Match otherwise: idx++ and stay in CHECK.
  - Mismatch: go to FAIL (feature on) or IDLE (feature off).
- Commands: append and play outside IDLE are ignored. There is no queueing.
- speed changes mid-playback have no effect until the next play.
- Timer is 25 bits, unsigned. STEP_CYCLES multiply uses the 3-bit speed, and the subtraction is clamped at MIN_CYCLES.
- length never wraps. idx ranges over 0..length-1.

Optional Feature:
- Macro: FAIL_FLASH_EN.
- Defined: mismatch goes to FAIL. FAIL flashes the expected colour (mem[idx]) 3 times, each flash on_cyc lit then on_cyc dark, then returns to IDLE. busy stays high throughout; guesses are ignored; clear still aborts.
- Undefined: the FAIL state and its flash counter are not compiled. Mismatch goes straight to IDLE after the result_valid pulse.

Decomposition:
- Package simon_pkg holds:
  - colour_t enum: RED=0, GREEN=1, BLUE=2, YELLOW=3.
  - pb_state_t enum: IDLE, PLAY_ON, PLAY_OFF, CHECK, FAIL.
  - function onehot(colour_t) returning logic [3:0].
  - FAIL_FLASHES=3.
- Sub-module seq_mem: MAX_LEN x 2-bit register file with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset on storage.

Test Plan:
All scenarios use BASE_CYCLES=10, STEP_CYCLES=2, MIN_CYCLES=4.
- Append RED, BLUE, GREEN; play with speed=0 -> led = 0001 for 10 cycles, 0000 for 10, 0100 for 10, 0000 for 10, 0010 for 10, 0000 for 10; play_done pulses once; length=3.
- Same sequence, play with speed=5 -> on/off time 4 cycles (clamped from 0); speed=2 -> 6 cycles.
- After playback, guesses RED, BLUE, GREEN -> three result_valid pulses with result_ok=1; round_done coincides with the third; busy falls the next cycle.
- Guesses RED, YELLOW -> second result_valid has result_ok=0. With FAIL_FLASH_EN: led = 0100 flashes 3 times (10 on / 10 off), then IDLE. Without: IDLE immediately.
- 33 appends -> length saturates at 32; the 33rd colour is not stored. Play with length 0 -> immediate play_done, led stays 0.
- Assert reset low mid-PLAY_ON -> led=0 and busy=0 asynchronously. Assert clear mid-CHECK -> next cycle IDLE and length=0. Append in the same cycle as play in IDLE -> length increments and no playback starts.
